serial_queue_bridge: RTL and testbench

Parametrised serial-to-parallel ingest path. It combines a deserializer, a word FIFO and two rate generators in a single clock domain. Serial bits are sampled on a slow "bit tick" and assembled into WIDTH-bit words. Complete words are pushed into a DEPTH-entry circular FIFO on a slower "queue tick", and the consumer pops words on the same tick. The rate generators are clock enables, not derived clocks, so the whole block runs on clock1M only.

---
 rtl/serial_queue_bridge.sv | 145 ++++++++++++++
 tb/tb_serial_queue_bridge.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_queue_bridge.sv
// Serial-to-parallel ingest: tick-gated deserializer feeding a DEPTH-entry word FIFO.
// Latency: word enters HOLD 1 cycle after its last bit, is enqueued on the next q_tick and is poppable on the one after.
// Backpressure: a full FIFO keeps the word in HOLD; bits offered while holding are dropped and flagged as overrun.
module serial_queue_bridge #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int BIT_DIV   = 10,
  parameter int Q_DIV     = 100,
  parameter int MSB_FIRST = 1,
  localparam int LW       = $clog2(DEPTH + 1)
) (
  input  logic             clock1M,
  input  logic             reset,
  input  logic             data_in,
  input  logic             write_in,
  input  logic             dequeue_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             status_out,
  output logic [LW-1:0]    len_out,
  output logic             full_out,
  output logic             empty_out,
  output logic             overrun_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int BW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int QW = (Q_DIV > 1) ? $clog2(Q_DIV) : 1;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  logic [BW-1:0]    bit_cnt;
  logic [QW-1:0]    q_cnt;
  logic             bit_tick;
  logic             q_tick;
  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shift_nxt;
  logic [CW-1:0]    bitcnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             accept_bit;
  logic             pop_ok;
  logic             push_ok;
  logic [LW-1:0]    len_nxt;

  assign bit_tick   = (bit_cnt == BW'(BIT_DIV - 1));
  assign q_tick     = (q_cnt == QW'(Q_DIV - 1));
  assign accept_bit = (state == COLLECT) && bit_tick && write_in;
  assign pop_ok     = q_tick && dequeue_in && !empty_out;
  // A full FIFO still accepts the held word when a pop frees a slot on the same tick.
  assign push_ok    = (state == HOLD) && q_tick && (!full_out || pop_ok);

  // Free-running bit-rate enable counter.
  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset)        bit_cnt <= '0;
    else if (bit_tick) bit_cnt <= '0;
    else               bit_cnt <= bit_cnt + BW'(1);
  end

  // Free-running queue-rate enable counter.
  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset)      q_cnt <= '0;
    else if (q_tick) q_cnt <= '0;
    else             q_cnt <= q_cnt + QW'(1);
  end

  // Shift direction: MSB-first fills from the bottom so the first bit ends up on top.
  always_comb begin
    shift_nxt = shreg;
    if (MSB_FIRST != 0) shift_nxt = {shreg[WIDTH-2:0], data_in};
    else                shift_nxt = {data_in, shreg[WIDTH-1:1]};
  end

  // Occupancy after this cycle's push/pop.
  always_comb begin
    len_nxt = len_out;
    if (push_ok && !pop_ok)      len_nxt = len_out + LW'(1);
    else if (pop_ok && !push_ok) len_nxt = len_out - LW'(1);
  end

  // Deserializer FSM with registered status and sticky overrun.
  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset) begin
      state       <= COLLECT;
      shreg       <= '0;
      bitcnt      <= '0;
      status_out  <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept_bit) begin
            shreg  <= shift_nxt;
            bitcnt <= bitcnt + CW'(1);
            if (bitcnt == CW'(WIDTH - 1)) begin
              state      <= HOLD;
              status_out <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bit_tick && write_in) overrun_out <= 1'b1;
          if (push_ok) begin
            bitcnt     <= '0;
            state      <= COLLECT;
            status_out <= 1'b0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  // Word storage; stale contents are unreachable once the pointers reset.
  always_ff @(posedge clock1M) begin
    if (push_ok) mem[tail] <= shreg;
  end

  // Pointers, registered flags and pop output.
  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      len_out    <= '0;
      full_out   <= 1'b0;
      empty_out  <= 1'b1;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= pop_ok;
      if (pop_ok) begin
        data_out <= mem[head];
        head     <= (head == PW'(DEPTH - 1)) ? '0 : head + PW'(1);
      end
      if (push_ok) tail <= (tail == PW'(DEPTH - 1)) ? '0 : tail + PW'(1);
      len_out   <= len_nxt;
      full_out  <= (len_nxt == LW'(DEPTH));
      empty_out <= (len_nxt == '0);
    end
  end

endmodule

// File: tb/tb_serial_queue_bridge.sv
// Bench for serial_queue_bridge: an MSB-first DEPTH=8 instance and an LSB-first DEPTH=5 instance.
// Expected words go into a scoreboard queue when sent and are compared when popped.
// Stimulus windows span exactly one tick period, so each bit or pop request is sampled once.
module tb_serial_queue_bridge;

  localparam int BIT_DIV = 2;
  localparam int Q_DIV   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       din = 1'b0, wr = 1'b0, deq = 1'b0;
  logic       sel = 1'b0;

  logic [7:0] dout_a, dout_b;
  logic       vld_a, vld_b, stat_a, stat_b, full_a, full_b, empty_a, empty_b, ovr_a, ovr_b;
  logic [3:0] len_a;
  logic [2:0] len_b;

  logic [7:0] dout_s;
  logic       vld_s, stat_s, full_s, empty_s, ovr_s;
  logic [3:0] len_s;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb [$];
  logic [7:0] last_word = 8'h00;

  always #5 clk = ~clk;

  serial_queue_bridge #(.WIDTH(8), .DEPTH(8), .BIT_DIV(BIT_DIV), .Q_DIV(Q_DIV), .MSB_FIRST(1)) dut_a (
    .clock1M(clk), .reset(reset), .data_in(din), .write_in(wr & ~sel), .dequeue_in(deq & ~sel),
    .data_out(dout_a), .data_valid(vld_a), .status_out(stat_a), .len_out(len_a),
    .full_out(full_a), .empty_out(empty_a), .overrun_out(ovr_a));

  serial_queue_bridge #(.WIDTH(8), .DEPTH(5), .BIT_DIV(BIT_DIV), .Q_DIV(Q_DIV), .MSB_FIRST(0)) dut_b (
    .clock1M(clk), .reset(reset), .data_in(din), .write_in(wr & sel), .dequeue_in(deq & sel),
    .data_out(dout_b), .data_valid(vld_b), .status_out(stat_b), .len_out(len_b),
    .full_out(full_b), .empty_out(empty_b), .overrun_out(ovr_b));

  assign dout_s  = sel ? dout_b  : dout_a;
  assign vld_s   = sel ? vld_b   : vld_a;
  assign stat_s  = sel ? stat_b  : stat_a;
  assign len_s   = sel ? {1'b0, len_b} : len_a;
  assign full_s  = sel ? full_b  : full_a;
  assign empty_s = sel ? empty_b : empty_a;
  assign ovr_s   = sel ? ovr_b   : ovr_a;

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic apply_reset();
    reset = 1'b0; din = 1'b0; wr = 1'b0; deq = 1'b0;
    sb.delete();
    last_word = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Holds write_in for exactly one bit-tick period.
  task automatic send_bit(input logic b);
    @(negedge clk);
    din = b; wr = 1'b1;
    repeat (BIT_DIV) @(negedge clk);
    wr = 1'b0;
  endtask

  // seq[7] is sent first.
  task automatic send_seq(input logic [7:0] seq);
    for (int i = 7; i >= 0; i--) send_bit(seq[i]);
  endtask

  // Sends w so that the selected instance reassembles it as w, then lets it drain to the FIFO.
  task automatic send_word(input logic [7:0] w);
    if (sel) send_seq(rev8(w));
    else     send_seq(w);
    wait_cyc(Q_DIV + 2);
  endtask

  // Holds dequeue_in for one queue-tick period and counts data_valid pulses.
  task automatic do_pop(input string name, input bit expect_pop);
    int         vcount;
    logic [7:0] got;
    logic [7:0] exp;
    vcount = 0;
    got    = 8'h00;
    @(negedge clk);
    deq = 1'b1;
    repeat (Q_DIV) begin
      @(negedge clk);
      if (vld_s) begin vcount++; got = dout_s; end
    end
    deq = 1'b0;
    @(negedge clk);
    if (vld_s) vcount++;
    checks++;
    if (expect_pop) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s: popped data_out=%h with %0d pulses but scoreboard is empty", name, got, vcount);
      end else begin
        exp = sb.pop_front();
        if (got !== exp || vcount !== 1) begin
          errors++;
          $display("FAIL %s: data_out=%h pulses=%0d, expected %h with 1 pulse", name, got, vcount, exp);
        end
        last_word = exp;
      end
    end else begin
      if (vcount !== 0 || dout_s !== last_word) begin
        errors++;
        $display("FAIL %s: pulses=%0d data_out=%h, expected 0 pulses and held %h", name, vcount, dout_s, last_word);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if ({dout_s, vld_s, stat_s, len_s, full_s, empty_s, ovr_s} !== {8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_values inst%0d: dout=%h vld=%b stat=%b len=%0d full=%b empty=%b ovr=%b, expected 00 0 0 0 0 1 0",
                 s, dout_s, vld_s, stat_s, len_s, full_s, empty_s, ovr_s);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_msb_first();
    sel = 1'b0;
    apply_reset();
    sb.push_back(8'hA5);
    send_seq(8'b1010_0101);
    checks++;
    if (stat_s !== 1'b1 || len_s !== 4'd0) begin
      errors++;
      $display("FAIL msb_hold: status=%b len=%0d, expected status 1 len 0", stat_s, len_s);
    end
    wait_cyc(Q_DIV + 2);
    checks++;
    if (stat_s !== 1'b0 || len_s !== 4'd1 || empty_s !== 1'b0) begin
      errors++;
      $display("FAIL msb_enqueue: status=%b len=%0d empty=%b, expected 0 1 0", stat_s, len_s, empty_s);
    end
    do_pop("msb_pop_a5", 1'b1);
  endtask

  task automatic test_lsb_first();
    sel = 1'b1;
    apply_reset();
    sb.push_back(8'hA5);
    send_seq(8'b1010_0101);
    wait_cyc(Q_DIV + 2);
    do_pop("lsb_pop_a5", 1'b1);
    sb.push_back(8'h03);
    send_seq(8'b1100_0000);
    wait_cyc(Q_DIV + 2);
    do_pop("lsb_pop_03", 1'b1);
  endtask

  task automatic test_full_overrun();
    sel = 1'b0;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      sb.push_back(8'(i));
      send_word(8'(i));
    end
    checks++;
    if (full_s !== 1'b1 || len_s !== 4'd8 || empty_s !== 1'b0 || stat_s !== 1'b0) begin
      errors++;
      $display("FAIL full8: full=%b len=%0d empty=%b status=%b, expected 1 8 0 0", full_s, len_s, empty_s, stat_s);
    end
    sb.push_back(8'h5A);
    send_word(8'h5A);
    checks++;
    if (stat_s !== 1'b1 || len_s !== 4'd8 || ovr_s !== 1'b0) begin
      errors++;
      $display("FAIL full_hold: status=%b len=%0d overrun=%b, expected 1 8 0", stat_s, len_s, ovr_s);
    end
    send_bit(1'b1);
    checks++;
    if (ovr_s !== 1'b1 || stat_s !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: overrun=%b status=%b, expected 1 1", ovr_s, stat_s);
    end
    do_pop("full_pop_00", 1'b1);
    checks++;
    if (len_s !== 4'd8 || full_s !== 1'b1 || stat_s !== 1'b0 || ovr_s !== 1'b1) begin
      errors++;
      $display("FAIL full_swap: len=%0d full=%b status=%b overrun=%b, expected 8 1 0 1", len_s, full_s, stat_s, ovr_s);
    end
    for (int i = 0; i < 8; i++) do_pop("full_drain", 1'b1);
    checks++;
    if (empty_s !== 1'b1 || len_s !== 4'd0 || full_s !== 1'b0) begin
      errors++;
      $display("FAIL full_drained: empty=%b len=%0d full=%b, expected 1 0 0", empty_s, len_s, full_s);
    end
  endtask

  task automatic test_wrap();
    sel = 1'b1;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      sb.push_back(8'h40 + 8'(i));
      send_word(8'h40 + 8'(i));
    end
    checks++;
    if (full_s !== 1'b1 || len_s !== 4'd5) begin
      errors++;
      $display("FAIL wrap_full5: full=%b len=%0d, expected 1 5", full_s, len_s);
    end
    for (int i = 5; i < 12; i++) begin
      sb.push_back(8'h40 + 8'(i));
      send_word(8'h40 + 8'(i));
      checks++;
      if (stat_s !== 1'b1 || len_s !== 4'd5) begin
        errors++;
        $display("FAIL wrap_hold%0d: status=%b len=%0d, expected 1 5", i, stat_s, len_s);
      end
      do_pop("wrap_pop", 1'b1);
      checks++;
      if (len_s !== 4'd5 || stat_s !== 1'b0) begin
        errors++;
        $display("FAIL wrap_len%0d: len=%0d status=%b, expected 5 0", i, len_s, stat_s);
      end
    end
    for (int i = 0; i < 5; i++) do_pop("wrap_drain", 1'b1);
    checks++;
    if (empty_s !== 1'b1 || len_s !== 4'd0) begin
      errors++;
      $display("FAIL wrap_empty: empty=%b len=%0d, expected 1 0", empty_s, len_s);
    end
  endtask

  task automatic test_pop_empty();
    do_pop("pop_empty", 1'b0);
    checks++;
    if (len_s !== 4'd0 || empty_s !== 1'b1) begin
      errors++;
      $display("FAIL pop_empty_len: len=%0d empty=%b, expected 0 1", len_s, empty_s);
    end
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    apply_reset();
    sb.push_back(8'h11); send_word(8'h11);
    sb.push_back(8'h22); send_word(8'h22);
    sb.push_back(8'h33); send_word(8'h33);
    do_pop("mid_pop_11", 1'b1);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    checks++;
    if (len_s !== 4'd2 || dout_s !== 8'h11) begin
      errors++;
      $display("FAIL mid_before: len=%0d dout=%h, expected 2 11", len_s, dout_s);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({dout_s, vld_s, stat_s, len_s, full_s, empty_s, ovr_s} !== {8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mid_async_reset: dout=%h vld=%b stat=%b len=%0d full=%b empty=%b ovr=%b, expected 00 0 0 0 0 1 0",
               dout_s, vld_s, stat_s, len_s, full_s, empty_s, ovr_s);
    end
    sb.delete();
    last_word = 8'h00;
    wait_cyc(2);
    reset = 1'b1;
    sb.push_back(8'hC3);
    send_word(8'hC3);
    checks++;
    if (len_s !== 4'd1) begin
      errors++;
      $display("FAIL mid_fresh_len: len=%0d, expected 1", len_s);
    end
    do_pop("mid_fresh_c3", 1'b1);
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_full_overrun();
    test_wrap();
    test_pop_empty();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
